// File: rtl/sub80_seq16.sv
// ============================================================================
// sub80_seq16 : 80-bit subtractor D = A - B - Bin, one 16-bit slice per clock
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub80_seq16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [79:0] A,
  input  logic [79:0] B,
  input  logic        Bin,
  output logic [79:0] D,
  output logic        Bout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic [79:0] r_a;
  logic [79:0] r_b;
  logic [79:0] r_d;
  logic        r_borrow;
  logic        r_bout;
  logic        w_accept;
  logic [16:0] w_diff;

  // Operands shift down each RUN cycle so the active slice is always bits [15:0].
  assign w_accept = start && (r_state != S_RUN);
  assign w_diff   = {1'b0, r_a[15:0]} - {1'b0, r_b[15:0]} - {16'h0, r_borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == 3'd4) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= 3'd0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= B;
      r_borrow <= Bin;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_cnt    <= 3'd0;
    end else if (r_state == S_RUN) begin
      r_a      <= {16'h0, r_a[79:16]};
      r_b      <= {16'h0, r_b[79:16]};
      r_borrow <= w_diff[16];
      case (r_cnt)
        3'd0:    r_d[15:0]  <= w_diff[15:0];
        3'd1:    r_d[31:16] <= w_diff[15:0];
        3'd2:    r_d[47:32] <= w_diff[15:0];
        3'd3:    r_d[63:48] <= w_diff[15:0];
        3'd4:    r_d[79:64] <= w_diff[15:0];
        default: r_d        <= r_d;
      endcase
      if (r_cnt == 3'd4) begin
        r_bout <= w_diff[16];
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sub80_seq16.sv
// ============================================================================
// tb_sub80_seq16 : self-checking bench for sub80_seq16 against an 81-bit model
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub80_seq16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [79:0] A = '0;
  logic [79:0] B = '0;
  logic        Bin = 1'b0;
  logic [79:0] D;
  logic        Bout;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  sub80_seq16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Runs one operation; entered #1 after an edge with the DUT in IDLE or DONE.
  // With chain=1 the caller issues the next op right in the DONE cycle.
  task automatic do_op(input logic [79:0] a, input logic [79:0] b, input logic bin,
                       input bit chain);
    logic [80:0] full;
    logic [79:0] exp_d;
    logic [80:0] mask;
    int lat;
    full  = {1'b0, a} - {1'b0, b} - {80'h0, bin};
    exp_d = full[79:0];
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    check_eq("accept_busy", {80'h0, busy}, 81'h1);
    check_eq("accept_D", {1'b0, D}, 81'h0);
    lat = 0;
    do begin
      start = 1'($urandom_range(0, 1));
      A = rnd80(); B = rnd80(); Bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (!done) begin
        mask = (81'h1 << (16 * lat)) - 81'h1;
        check_eq("partial_D", {1'b0, D}, {1'b0, exp_d} & mask);
        check_eq("partial_Bout", {80'h0, Bout}, 81'h0);
      end
    end while (!done && lat < 20);
    start = 1'b0;
    check_eq("latency", 81'(lat), 81'd5);
    check_eq("result_D", {1'b0, D}, {1'b0, exp_d});
    check_eq("result_Bout", {80'h0, Bout}, {80'h0, full[80]});
    check_eq("done_busy", {80'h0, busy}, 81'h0);
    if (!chain) begin
      @(posedge clk); #1;
      check_eq("done_pulse_end", {80'h0, done}, 81'h0);
      check_eq("hold_D", {1'b0, D}, {1'b0, exp_d});
      check_eq("hold_Bout", {80'h0, Bout}, {80'h0, full[80]});
    end
  endtask

  initial begin
    logic [80:0] full;
    bit seen_done;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_D", {1'b0, D}, 81'h0);
    check_eq("rst_flags", {78'h0, Bout, busy, done}, 81'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(80'h1, 80'h1, 1'b0, 1'b0);
    do_op(80'h0, 80'h1, 1'b0, 1'b0);
    do_op(80'h0, 80'h0, 1'b1, 1'b0);
    do_op(80'h00000001000000000000, 80'h1, 1'b0, 1'b0);
    do_op(80'hABCDEF1234567890FFFF, 80'h11111111111111111111, 1'b1, 1'b0);
    do_op('1, '1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_op(rnd80(), rnd80(), 1'($urandom_range(0, 1)), 1'b0);
    end

    // back-to-back stream, start taken in each DONE cycle
    for (int i = 0; i < 8; i++) begin
      do_op(rnd80(), rnd80(), 1'($urandom_range(0, 1)), (i != 7));
    end

    // reset in the middle of RUN (cnt=2)
    A = rnd80(); B = rnd80(); Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrst_D", {1'b0, D}, 81'h0);
    check_eq("midrst_flags", {78'h0, Bout, busy, done}, 81'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check_eq("midrst_quiet", {80'h0, seen_done}, 81'h0);
    do_op(80'h12345, 80'h12346, 1'b0, 1'b0);
    full = {1'b0, 80'h12345} - {1'b0, 80'h12346};
    check_eq("post_rst_model", {1'b0, D}, {1'b0, full[79:0]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
